// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage front end for MemoryModule. Latches the EX/MEM
//               load/store, stalls the pipeline across the multi-cycle
//               access, serves COM1 status reads locally and holds COM1
//               data stores until the UART transmitter is idle.
//               Optional macro UART_TX_TIMEOUT_EN adds a TXWAIT watchdog
//               (TX_TIMEOUT cycles) that abandons the store and sets the
//               sticky err_timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter logic [15:0] COM1_DATA     = 16'hBF00,
   parameter logic [15:0] COM1_STATUS   = 16'hBF01
`ifdef UART_TX_TIMEOUT_EN
   ,parameter int unsigned TX_TIMEOUT   = 1024
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        stall,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic [15:0] Address,
   output logic [15:0] WriteData,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [15:0] ReadData,
   input  logic        tbre,
   input  logic        tsre,
   input  logic        data_ready,
   output logic        err_timeout
);

   localparam int unsigned    ACW      = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [ACW-1:0] ACC_LAST = ACW'(ACCESS_CYCLES - 1);

`ifdef UART_TX_TIMEOUT_EN
   localparam int unsigned    TOW      = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
   localparam logic [TOW-1:0] TO_LAST  = TOW'(TX_TIMEOUT - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TXWAIT = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_wr;
   logic [ACW-1:0]   r_acc_cnt;
   logic             w_tx_idle;

`ifdef UART_TX_TIMEOUT_EN
   logic [TOW-1:0]   r_to_cnt;
   logic             r_err_timeout;
`endif

   assign w_tx_idle = tbre & tsre;

   // The pipeline is held from the cycle a request appears until the DONE cycle.
   assign stall = req_valid & (r_state != S_DONE);

   // Load result is presented only if the requester is still there (not flushed).
   assign rdata_valid = req_valid & (r_state == S_DONE) & ~r_wr;

`ifdef UART_TX_TIMEOUT_EN
   assign err_timeout = r_err_timeout;
`else
   assign err_timeout = 1'b0;
`endif

   // Request sequencer: latches the op, runs the access and registers all memory-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wr          <= 1'b0;
         r_acc_cnt     <= '0;
         rdata         <= 16'h0000;
         Address       <= 16'h0000;
         WriteData     <= 16'h0000;
         MemRead       <= 1'b0;
         MemWrite      <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
         r_to_cnt      <= '0;
         r_err_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_wr      <= req_write;
                  r_acc_cnt <= '0;
`ifdef UART_TX_TIMEOUT_EN
                  r_to_cnt  <= '0;
`endif
                  if (req_addr == COM1_STATUS) begin
                     // Status register lives here; stores to it are dropped.
                     if (!req_write) begin
                        rdata <= {14'b0, data_ready, w_tx_idle};
                     end
                     r_state <= S_DONE;
                  end else begin
                     Address   <= req_addr;
                     WriteData <= req_wdata;
                     if (req_write && (req_addr == COM1_DATA)) begin
                        r_state <= S_TXWAIT;
                     end else begin
                        MemRead  <= ~req_write;
                        MemWrite <= req_write;
                        r_state  <= S_ACCESS;
                     end
                  end
               end
            end

            S_TXWAIT: begin
               if (w_tx_idle) begin
                  MemRead  <= ~r_wr;
                  MemWrite <= r_wr;
                  r_state  <= S_ACCESS;
`ifdef UART_TX_TIMEOUT_EN
               end else if (r_to_cnt == TO_LAST) begin
                  // Give up on the UART: release the pipeline without writing.
                  r_err_timeout <= 1'b1;
                  r_state       <= S_DONE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
`endif
               end
            end

            S_ACCESS: begin
               if (r_acc_cnt == ACC_LAST) begin
                  MemRead  <= 1'b0;
                  MemWrite <= 1'b0;
                  if (!r_wr) begin
                     rdata <= ReadData;
                  end
                  r_state <= S_DONE;
               end else begin
                  r_acc_cnt <= r_acc_cnt + 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               MemRead  <= 1'b0;
               MemWrite <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl: table of single ops
//               plus hand-written UART wait, flush and reset sequences.
//               Load results go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        stall;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic [15:0] Address;
   logic [15:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] ReadData;
   logic        tbre;
   logic        tsre;
   logic        data_ready;
   logic        err_timeout;

   mem_stage_ctrl #(
      .ACCESS_CYCLES(2)
`ifdef UART_TX_TIMEOUT_EN
      ,.TX_TIMEOUT(8)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .Address     (Address),
      .WriteData   (WriteData),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .ReadData    (ReadData),
      .tbre        (tbre),
      .tsre        (tsre),
      .data_ready  (data_ready),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] sb_q[$];

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] mem;
      logic        tb;
      logic        ts;
      logic        dr;
      int          exp_stall;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] mem, input logic tb, input logic ts, input logic dr,
                               input int st, input int rd, input int wrc);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.mem = mem;
      v.tb = tb; v.ts = ts; v.dr = dr;
      v.exp_stall = st; v.exp_rd = rd; v.exp_wr = wrc;
      return v;
   endfunction

   // Reference: status register is local, everything else comes from memory.
   function automatic logic [15:0] exp_rdata(input vec_t v);
      if (v.addr == 16'hBF01) return {14'b0, v.dr, v.tb & v.ts};
      return v.mem;
   endfunction

   task automatic sb_pop_check(input string tag);
      logic [15:0] e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_unexpected_rdata_valid: got rdata %0h expected no pulse", tag, rdata);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_rdata"}, rdata, e);
      end
   endtask

   task automatic drive(input vec_t v);
      req_valid  = 1'b1;
      req_write  = v.wr;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      ReadData   = v.mem;
      tbre       = v.tb;
      tsre       = v.ts;
      data_ready = v.dr;
   endtask

   // Observe from the current cycle until stall drops (the DONE cycle).
   task automatic watch(input vec_t v, input string tag);
      int n_st = 0, n_rd = 0, n_wr = 0, n_val = 0;
      bit both = 0, addr_bad = 0, wd_bad = 0, done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (MemRead) begin
            n_rd++;
            if (Address !== v.addr) addr_bad = 1;
         end
         if (MemWrite) begin
            n_wr++;
            if (Address !== v.addr || WriteData !== v.wdata) wd_bad = 1;
         end
         if (MemRead && MemWrite) both = 1;
         if (rdata_valid) begin
            n_val++;
            sb_pop_check(tag);
         end
         if (stall) n_st++;
         else done = 1;
         if (!done) begin
            @(posedge clk); #1;
         end
      end
      check({tag, "_completed"}, done, 1);
      check({tag, "_stall_cycles"}, n_st, v.exp_stall);
      check({tag, "_memread_cycles"}, n_rd, v.exp_rd);
      check({tag, "_memwrite_cycles"}, n_wr, v.exp_wr);
      check({tag, "_rd_wr_exclusive"}, both, 0);
      check({tag, "_addr_bad"}, addr_bad, 0);
      check({tag, "_wdata_bad"}, wd_bad, 0);
      check({tag, "_valid_pulses"}, n_val, v.wr ? 0 : 1);
   endtask

   task automatic run_op(input vec_t v, input string tag);
      @(posedge clk); #1;
      drive(v);
      if (!v.wr) sb_q.push_back(exp_rdata(v));
      watch(v, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   n_rd, n_wr, n_val, n_st;

      //                wr    addr      wdata     mem      tb ts dr st rd wr
      tbl[0] = mk(1'b0, 16'h4000, 16'h0000, 16'h1234, 1, 1, 0, 3, 2, 0);
      tbl[1] = mk(1'b1, 16'h9000, 16'hBEEF, 16'h0000, 1, 1, 0, 3, 0, 2);
      tbl[2] = mk(1'b0, 16'hBF01, 16'h0000, 16'hDEAD, 1, 1, 1, 1, 0, 0);
      tbl[3] = mk(1'b0, 16'hBF01, 16'h0000, 16'hDEAD, 1, 0, 1, 1, 0, 0);
      tbl[4] = mk(1'b0, 16'hBF01, 16'h0000, 16'hDEAD, 1, 1, 0, 1, 0, 0);
      tbl[5] = mk(1'b1, 16'hBF01, 16'h1234, 16'h0000, 1, 1, 0, 1, 0, 0);
      tbl[6] = mk(1'b0, 16'hBF00, 16'h0000, 16'h0055, 1, 1, 0, 3, 2, 0);
      tbl[7] = mk(1'b1, 16'hBF00, 16'h0041, 16'h0000, 1, 1, 0, 4, 0, 2);
      tbl[8] = mk(1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 1, 1, 0, 3, 2, 0);
      tbl[9] = mk(1'b1, 16'h0002, 16'hFFFF, 16'h0000, 1, 1, 0, 3, 0, 2);

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0;
      req_wdata = 16'h0; ReadData = 16'h0; tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_stall", stall, 0);
      check("reset_memread", MemRead, 0);
      check("reset_memwrite", MemWrite, 0);
      check("reset_rdata", rdata, 16'h0000);
      check("reset_rdata_valid", rdata_valid, 0);
      check("reset_address", Address, 16'h0000);
      check("reset_writedata", WriteData, 16'h0000);
      check("reset_err_timeout", err_timeout, 0);
      rst = 1'b0;

      // Table ops, issued back-to-back (each starts in the cycle after DONE)
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i], $sformatf("op%0d", i));
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("idle_address_held", Address, 16'h0002);
      check("idle_wdata_held", WriteData, 16'hFFFF);

      // UART store held off while the shift register is busy
      @(posedge clk); #1;
      v = mk(1'b1, 16'hBF00, 16'h0041, 16'h0000, 1, 0, 0, 3, 0, 2);
      drive(v);
      n_wr = 0; n_st = 0;
      repeat (5) begin
         @(negedge clk);
         if (MemWrite) n_wr++;
         if (stall) n_st++;
         @(posedge clk); #1;
      end
      check("txwait_no_memwrite", n_wr, 0);
      check("txwait_stall_held", n_st, 5);
      tsre = 1'b1;
      watch(v, "txwait");
      check("txwait_err_timeout", err_timeout, 0);

      // Flushed load: access completes, no valid pulse, later request changes ignored
      @(posedge clk); #1;
      v = mk(1'b0, 16'h1000, 16'h0000, 16'h7777, 1, 1, 0, 0, 0, 0);
      drive(v);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 16'h3333; req_write = 1'b1;
      n_rd = 0; n_wr = 0; n_val = 0; n_st = 0;
      repeat (6) begin
         @(negedge clk);
         if (MemRead) begin
            n_rd++;
            check("flush_ld_address", Address, 16'h1000);
         end
         if (MemWrite) n_wr++;
         if (rdata_valid) n_val++;
         if (stall) n_st++;
         @(posedge clk); #1;
      end
      check("flush_ld_memread", n_rd, 2);
      check("flush_ld_memwrite", n_wr, 0);
      check("flush_ld_no_valid", n_val, 0);
      check("flush_ld_no_stall", n_st, 0);
      check("flush_ld_rdata", rdata, 16'h7777);

      // Flushed store: write is never torn
      v = mk(1'b1, 16'h2222, 16'h1111, 16'h0000, 1, 1, 0, 0, 0, 0);
      drive(v);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = 16'h0BAD;
      n_wr = 0;
      repeat (6) begin
         @(negedge clk);
         if (MemWrite) begin
            n_wr++;
            check("flush_st_wdata", WriteData, 16'h1111);
         end
         @(posedge clk); #1;
      end
      check("flush_st_memwrite", n_wr, 2);

      // Reset in the middle of an access
      v = mk(1'b1, 16'h5000, 16'h9999, 16'h0000, 1, 1, 0, 0, 0, 0);
      drive(v);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_memwrite_before", MemWrite, 1);
      #2;
      rst = 1'b1; req_valid = 1'b0;
      #1;
      check("rstmid_stall", stall, 0);
      check("rstmid_memread", MemRead, 0);
      check("rstmid_memwrite", MemWrite, 0);
      check("rstmid_rdata", rdata, 16'h0000);
      check("rstmid_rdata_valid", rdata_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rstmid_memwrite_after", MemWrite, 0);

      // Post-reset load still works
      run_op(tbl[0], "post_rst");
      @(posedge clk); #1;
      req_valid = 1'b0;

`ifdef UART_TX_TIMEOUT_EN
      // UART transmitter stuck busy: watchdog releases the stall without writing
      @(posedge clk); #1;
      v = mk(1'b1, 16'hBF00, 16'h0041, 16'h0000, 0, 1, 0, 9, 0, 0);
      drive(v);
      watch(v, "timeout");
      check("timeout_err_set", err_timeout, 1);
      @(posedge clk); #1;
      req_valid = 1'b0; tbre = 1'b1;
      repeat (3) @(negedge clk);
      check("timeout_err_sticky", err_timeout, 1);
`endif

      check("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
